// File: rtl/led_matrix_serializer_if.sv
// Bus between the frame builder and the LED matrix serializer: frame inputs and board pins.
// The frame builder offers wr_seq/wr_seq_nbits at all times; a frame is taken only in a cycle where
// the serializer is idle and cnt_100M==0. There is no valid/ready back-pressure, so a busy
// serializer drops the trigger.
interface led_matrix_serializer_if #(
   parameter int SEQ_W = 394
);
   logic [31:0]      cnt_100M;
   logic [SEQ_W-1:0] wr_seq;
   logic [31:0]      wr_seq_nbits;
   logic             cs;
   logic             write;
   logic             data;
   logic             debug;
   logic [2:0]       state_dbg;

   modport master (
      output cnt_100M, wr_seq, wr_seq_nbits,
      input  cs, write, data, debug, state_dbg
   );

   modport slave (
      input  cnt_100M, wr_seq, wr_seq_nbits,
      output cs, write, data, debug, state_dbg
   );
endinterface

// File: rtl/led_matrix_serializer.sv
// 3-wire (cs/write/data) transmitter for the 16x24 LED matrix board: init command burst
// after reset, then one frame per zero crossing of the free-running counter.
module led_matrix_serializer #(
   parameter int SEQ_W = 394,
   parameter int HALF  = 50,
   parameter int CMD_W = 12
) (
   input logic                    clk,
   input logic                    rst_n,
   led_matrix_serializer_if.slave bus
);
   localparam int            HW        = (HALF > 1) ? $clog2(HALF) : 1;
   localparam logic [HW-1:0] HALF_LAST = HW'(HALF - 1);
   localparam logic [8:0]    CMD_LAST  = 9'(CMD_W - 1);
   localparam logic [8:0]    SEQ_MAX   = 9'(SEQ_W);

   typedef enum logic [2:0] {
      INIT_SEND = 3'd0,
      INIT_GAP  = 3'd1,
      IDLE      = 3'd2,
      SEND      = 3'd3,
      GAP       = 3'd4
   } state_t;

   state_t           state;
   logic [HW-1:0]    half_cnt;
   logic             phase;
   logic [8:0]       bit_cnt;
   logic [1:0]       cmd_idx;
   logic [SEQ_W-1:0] frame_q;
   logic             cs_q;
   logic             write_q;
   logic             data_q;
   logic             debug_q;

   logic             half_done;
   logic [8:0]       bit_m1;
   logic [8:0]       nbits_eff;
   logic [8:0]       nbits_last;
   logic             next_bit;

   // Init words are {3'b100, code, 1'b0}; index 3 means all commands are done.
   function automatic logic cmd_bit(input logic [1:0] idx, input logic [3:0] pos);
      logic [11:0] w;
      case (idx)
         2'd0:    w = {3'b100, 8'h01, 1'b0};
         2'd1:    w = {3'b100, 8'h03, 1'b0};
         2'd2:    w = {3'b100, 8'h20, 1'b0};
         default: w = 12'h000;
      endcase
      return w[pos];
   endfunction

   always_comb begin
      half_done = (half_cnt == HALF_LAST);
      bit_m1    = bit_cnt - 9'd1;
      nbits_eff = (bus.wr_seq_nbits > 32'(SEQ_W)) ? SEQ_MAX : bus.wr_seq_nbits[8:0];
      nbits_last = nbits_eff - 9'd1;
      next_bit  = (state == SEND) ? frame_q[bit_m1] : cmd_bit(cmd_idx, bit_m1[3:0]);
   end

   // phase 0 is the write-low half of a cell (or first half of a gap), phase 1 the high half.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= INIT_SEND;
         half_cnt <= '0;
         phase    <= 1'b0;
         bit_cnt  <= CMD_LAST;
         cmd_idx  <= 2'd0;
         frame_q  <= '0;
         cs_q     <= 1'b1;
         write_q  <= 1'b1;
         data_q   <= 1'b0;
         debug_q  <= 1'b0;
      end else begin
         case (state)
            INIT_SEND, SEND: begin
               if (cs_q) begin
                  // Only reached on the first edge after reset: start command 0.
                  cs_q     <= 1'b0;
                  write_q  <= 1'b0;
                  data_q   <= cmd_bit(cmd_idx, CMD_LAST[3:0]);
                  half_cnt <= '0;
                  phase    <= 1'b0;
                  bit_cnt  <= CMD_LAST;
               end else if (!half_done) begin
                  half_cnt <= half_cnt + 1'b1;
               end else begin
                  half_cnt <= '0;
                  if (!phase) begin
                     phase   <= 1'b1;
                     write_q <= 1'b1;
                  end else begin
                     phase   <= 1'b0;
                     bit_cnt <= bit_m1;
                     if (bit_cnt == 9'd0) begin
                        cs_q <= 1'b1;
                        if (state == SEND) begin
                           state   <= GAP;
                           debug_q <= ~debug_q;
                        end else begin
                           state   <= INIT_GAP;
                           cmd_idx <= cmd_idx + 2'd1;
                        end
                     end else begin
                        write_q <= 1'b0;
                        data_q  <= next_bit;
                     end
                  end
               end
            end

            INIT_GAP, GAP: begin
               if (!half_done) begin
                  half_cnt <= half_cnt + 1'b1;
               end else if (!phase) begin
                  half_cnt <= '0;
                  phase    <= 1'b1;
               end else begin
                  half_cnt <= '0;
                  phase    <= 1'b0;
                  if (state == INIT_GAP && cmd_idx != 2'd3) begin
                     state   <= INIT_SEND;
                     cs_q    <= 1'b0;
                     write_q <= 1'b0;
                     data_q  <= cmd_bit(cmd_idx, CMD_LAST[3:0]);
                     bit_cnt <= CMD_LAST;
                  end else begin
                     state <= IDLE;
                  end
               end
            end

            IDLE: begin
               if (bus.cnt_100M == 32'd0) begin
                  frame_q <= bus.wr_seq;
                  if (nbits_eff != 9'd0) begin
                     state    <= SEND;
                     cs_q     <= 1'b0;
                     write_q  <= 1'b0;
                     data_q   <= bus.wr_seq[nbits_last];
                     bit_cnt  <= nbits_last;
                     half_cnt <= '0;
                     phase    <= 1'b0;
                  end
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

   assign bus.cs        = cs_q;
   assign bus.write     = write_q;
   assign bus.data      = data_q;
   assign bus.debug     = debug_q;
   assign bus.state_dbg = state;
endmodule

// File: tb/tb_led_matrix_serializer.sv
// Bench for led_matrix_serializer: a pin-level monitor rebuilds each cs-low burst and compares
// it against bit sequences derived from the board protocol.
module tb_led_matrix_serializer;
   localparam int SEQ_W = 394;
   localparam int HALF  = 2;

   logic clk = 1'b0;
   logic rst_n;

   led_matrix_serializer_if #(.SEQ_W(SEQ_W)) bus ();

   led_matrix_serializer #(.SEQ_W(SEQ_W), .HALF(HALF), .CMD_W(12)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [511:0] bits;
      int           nb;
      int           len;
      int           gap;
   } burst_t;

   burst_t      bursts[$];
   logic [0:0]  exp_q[$];
   int          checks = 0;
   int          failures = 0;
   logic        exp_debug = 1'b0;

   task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Pin monitor: counts cs-low cycles, samples data on each write rising edge.
   initial begin
      logic [511:0] cur_bits;
      int           cur_nb, cur_len, gap_cnt;
      logic         prev_cs, prev_wr;
      cur_bits = '0; cur_nb = 0; cur_len = 0; gap_cnt = 0; prev_cs = 1'b1; prev_wr = 1'b1;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            cur_bits = '0; cur_nb = 0; cur_len = 0; gap_cnt = 0; prev_cs = 1'b1; prev_wr = 1'b1;
         end else begin
            if (!bus.cs) begin
               cur_len++;
               if (bus.write && !prev_wr) begin
                  cur_bits = {cur_bits[510:0], bus.data};
                  cur_nb++;
               end
            end else if (!prev_cs) begin
               bursts.push_back('{bits: cur_bits, nb: cur_nb, len: cur_len, gap: gap_cnt});
               cur_bits = '0; cur_nb = 0; cur_len = 0; gap_cnt = 1;
            end else begin
               gap_cnt++;
            end
            prev_cs = bus.cs;
            prev_wr = bus.write;
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   task automatic wait_bursts(input string tag, input int k, input int budget);
      int c = 0;
      while (bursts.size() < k && c < budget) begin
         @(negedge clk);
         c++;
      end
      check({tag, "_arrived"}, 512'(bursts.size() >= k), 512'(1));
   endtask

   function automatic logic [SEQ_W-1:0] rand_seq();
      logic [SEQ_W-1:0] r = '0;
      for (int i = 0; i < 13; i++) r = {r[361:0], $urandom()};
      return r;
   endfunction

   task automatic check_init(input string tag, input logic [11:0] word, input bit check_gap);
      burst_t b;
      if (bursts.size() == 0) return;
      b = bursts.pop_front();
      check({tag, "_bits"}, b.bits, 512'(word));
      check({tag, "_nb"}, 512'(b.nb), 512'(12));
      check({tag, "_len"}, 512'(b.len), 512'(12 * 2 * HALF));
      if (check_gap) check({tag, "_gap"}, 512'(b.gap), 512'(2 * HALF));
   endtask

   task automatic pulse_trigger();
      @(negedge clk);
      bus.cnt_100M = 32'd0;
      @(negedge clk);
      bus.cnt_100M = $urandom_range(1, 100_000);
   endtask

   // Reference model: n = min(nbits, SEQ_W); bits go out from index n-1 down to 0.
   task automatic run_frame(input string tag, input logic [SEQ_W-1:0] seq, input int nbits,
                            input bit stress);
      int           n;
      logic [511:0] expv;
      burst_t       b;
      n = (nbits > SEQ_W) ? SEQ_W : nbits;
      exp_q.delete();
      for (int i = n - 1; i >= 0; i--) exp_q.push_back(seq[i]);
      expv = '0;
      foreach (exp_q[i]) expv = {expv[510:0], exp_q[i]};
      bus.wr_seq = seq;
      bus.wr_seq_nbits = nbits;
      pulse_trigger();
      bus.wr_seq = rand_seq();
      if (n == 0) begin
         repeat (40) @(negedge clk);
         check({tag, "_no_burst"}, 512'(bursts.size()), 512'(0));
         check({tag, "_cs_idle"}, 512'(bus.cs), 512'(1));
         check({tag, "_debug"}, 512'(bus.debug), 512'(exp_debug));
         return;
      end
      check({tag, "_lat_cs"}, 512'(bus.cs), 512'(0));
      check({tag, "_lat_write"}, 512'(bus.write), 512'(0));
      check({tag, "_lat_data"}, 512'(bus.data), 512'(exp_q[0]));
      if (stress) begin
         repeat (100) @(negedge clk);
         bus.cnt_100M = 32'd0;
         @(negedge clk);
         bus.cnt_100M = 32'd9;
         repeat (600) @(negedge clk);
         bus.cnt_100M = 32'd0;
         repeat (3) @(negedge clk);
         bus.cnt_100M = 32'd11;
      end
      wait_bursts(tag, 1, 2 * HALF * SEQ_W + 200);
      if (stress) begin
         // Zeros landing in GAP must be dropped too.
         bus.cnt_100M = 32'd0;
         repeat (2) @(negedge clk);
         bus.cnt_100M = 32'd13;
      end
      if (bursts.size() > 0) begin
         b = bursts.pop_front();
         check({tag, "_bits"}, b.bits, expv);
         check({tag, "_nb"}, 512'(b.nb), 512'(n));
         check({tag, "_len"}, 512'(b.len), 512'(n * 2 * HALF));
      end
      exp_debug = ~exp_debug;
      check({tag, "_debug"}, 512'(bus.debug), 512'(exp_debug));
      repeat (30) @(negedge clk);
      check({tag, "_no_restart"}, 512'(bursts.size()), 512'(0));
   endtask

   initial begin
      logic [SEQ_W-1:0] s;
      rst_n = 1'b0;
      bus.cnt_100M = 32'd7;
      bus.wr_seq = '0;
      bus.wr_seq_nbits = 32'd0;
      repeat (3) @(negedge clk);
      check("rst_cs", 512'(bus.cs), 512'(1));
      check("rst_write", 512'(bus.write), 512'(1));
      check("rst_data", 512'(bus.data), 512'(0));
      check("rst_debug", 512'(bus.debug), 512'(0));

      rst_n = 1'b1;
      wait_bursts("init", 3, 400);
      check_init("init0", 12'b100000000010, 1'b0);
      check_init("init1", 12'b100000000110, 1'b1);
      check_init("init2", 12'b100001000000, 1'b1);
      repeat (10) @(negedge clk);

      s = (394'd5 << 391) | 394'd1;
      run_frame("frame_full", s, 394, 1'b1);

      s = rand_seq();
      s[9:0] = 10'b1010000000;
      run_frame("frame_n10", s, 10, 1'b0);
      run_frame("frame_n0", rand_seq(), 0, 1'b0);
      run_frame("frame_clamp", rand_seq(), 1000, 1'b0);
      run_frame("frame_n1", rand_seq(), 1, 1'b0);
      for (int i = 0; i < 3; i++) run_frame("frame_rand", rand_seq(), $urandom_range(1, SEQ_W), 1'b0);

      // Reset in the middle of a frame.
      bus.wr_seq = rand_seq();
      bus.wr_seq_nbits = 32'd394;
      pulse_trigger();
      repeat (30) @(negedge clk);
      #1 rst_n = 1'b0;
      #1;
      check("midrst_cs", 512'(bus.cs), 512'(1));
      check("midrst_write", 512'(bus.write), 512'(1));
      check("midrst_data", 512'(bus.data), 512'(0));
      check("midrst_debug", 512'(bus.debug), 512'(0));
      exp_debug = 1'b0;
      @(negedge clk);
      bursts.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      wait_bursts("reinit", 3, 400);
      check_init("reinit0", 12'b100000000010, 1'b0);
      check_init("reinit1", 12'b100000000110, 1'b1);
      check_init("reinit2", 12'b100001000000, 1'b1);
      repeat (10) @(negedge clk);
      run_frame("frame_after_rst", rand_seq(), $urandom_range(1, SEQ_W), 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
